// File: rtl/rx_cp_remove_s2p.sv
// Receive-side cyclic-prefix removal and serial-to-parallel gather for the 16-point FFT.
// Optional CP-vs-body-tail consistency check is compiled in with `define S2P_CP_CHECK_EN.
module rx_cp_remove_s2p #(
    parameter int portWidth = 16,
    parameter int N         = 16,
    parameter int CPLen     = 4
) (
    input  logic                   S2PCLK,
    input  logic                   S2PRST,
    input  logic [portWidth-1:0]   S2PinR,
    input  logic [portWidth-1:0]   S2PinI,
    input  logic                   S2PinValid,
    input  logic                   S2PinSync,
    output logic [N*portWidth-1:0] S2PoutR,
    output logic [N*portWidth-1:0] S2PoutI,
    output logic                   S2PoutValid,
    output logic                   S2PcpErr
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic {SKIP_CP, COLLECT} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 cap_we, frame_done, frame_pend;
    logic [portWidth-1:0] cap_r [N];
    logic [portWidth-1:0] cap_i [N];

    // NOTE: state advances only on qualified samples; idle cycles freeze the whole FSM.
    always_ff @(posedge S2PCLK or negedge S2PRST) begin
        if (!S2PRST) begin
            state <= SKIP_CP;
            cnt   <= '0;
        end else if (S2PinValid) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            SKIP_CP: if (cnt == CNT_W'(CPLen - 1)) begin
                cnt_nxt   = '0;
                state_nxt = COLLECT;
            end
            COLLECT: if (cnt == CNT_W'(N - 1)) begin
                cnt_nxt   = '0;
                state_nxt = SKIP_CP;
            end
            default: state_nxt = SKIP_CP;
        endcase
        // The sync sample itself is CP sample 0.
        if (S2PinSync) begin
            if (CPLen == 1) begin
                state_nxt = COLLECT;
                cnt_nxt   = '0;
            end else begin
                state_nxt = SKIP_CP;
                cnt_nxt   = CNT_W'(1);
            end
        end
    end

    always_comb begin
        cap_we     = S2PinValid && (state == COLLECT);
        frame_done = cap_we && (cnt == CNT_W'(N - 1));
    end

    // NOTE: the capture array is cleared on reset so a partial frame never leaks stale data.
    always_ff @(posedge S2PCLK or negedge S2PRST) begin
        if (!S2PRST) begin
            for (int k = 0; k < N; k++) begin
                cap_r[k] <= '0;
                cap_i[k] <= '0;
            end
        end else if (cap_we) begin
            cap_r[cnt] <= S2PinR;
            cap_i[cnt] <= S2PinI;
        end
    end

    // Outputs copy one cycle after completion, so slot N-1 is already in the array.
    always_ff @(posedge S2PCLK or negedge S2PRST) begin
        if (!S2PRST) begin
            frame_pend  <= 1'b0;
            S2PoutValid <= 1'b0;
            S2PoutR     <= '0;
            S2PoutI     <= '0;
        end else begin
            frame_pend  <= frame_done;
            S2PoutValid <= frame_pend;
            if (frame_pend) begin
                for (int k = 0; k < N; k++) begin
                    S2PoutR[k*portWidth +: portWidth] <= cap_r[k];
                    S2PoutI[k*portWidth +: portWidth] <= cap_i[k];
                end
            end
        end
    end

`ifdef S2P_CP_CHECK_EN
    localparam int CP_W = (CPLen > 1) ? $clog2(CPLen) : 1;

    logic [portWidth-1:0] cp_r [CPLen];
    logic [portWidth-1:0] cp_i [CPLen];
    logic                 cp_we, cp_trunc, trunc_evt, cp_mismatch, err_pend;
    logic [CP_W-1:0]      cp_idx;

    always_comb begin
        cp_we     = S2PinValid && ((state == SKIP_CP) || S2PinSync);
        cp_idx    = S2PinSync ? '0 : CP_W'(cnt);
        trunc_evt = S2PinValid && S2PinSync && (state == SKIP_CP) && (cnt != '0);
    end

    // Body slot N-1 is being written this edge, so compare against the live input for it.
    always_comb begin
        cp_mismatch = cp_trunc;
        for (int j = 0; j < CPLen; j++) begin
            if (N - CPLen + j == N - 1) begin
                if ((cp_r[j] != S2PinR) || (cp_i[j] != S2PinI)) cp_mismatch = 1'b1;
            end else begin
                if ((cp_r[j] != cap_r[N-CPLen+j]) || (cp_i[j] != cap_i[N-CPLen+j])) cp_mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge S2PCLK or negedge S2PRST) begin
        if (!S2PRST) begin
            for (int j = 0; j < CPLen; j++) begin
                cp_r[j] <= '0;
                cp_i[j] <= '0;
            end
            cp_trunc <= 1'b0;
            err_pend <= 1'b0;
            S2PcpErr <= 1'b0;
        end else begin
            if (cp_we) begin
                cp_r[cp_idx] <= S2PinR;
                cp_i[cp_idx] <= S2PinI;
            end
            if (trunc_evt)       cp_trunc <= 1'b1;
            else if (frame_done) cp_trunc <= 1'b0;
            err_pend <= frame_done && cp_mismatch;
            S2PcpErr <= err_pend;
        end
    end
`else
    assign S2PcpErr = 1'b0;
`endif

endmodule
